// File: rtl/drbg_stream_consumer.sv
// drbg_stream_consumer: banked DRBG keystream buffer emitting one slice per pixel strobe; define STALL_COUNT_EN for the stall_count output
module drbg_stream_consumer #(
  parameter int DATA_WIDTH_IN  = 256,
  parameter int DATA_WIDTH_OUT = 8,
  parameter int NUM_BANKS      = 2,
  parameter int IDLE_HOLD      = 3,
  parameter int VALID_HOLD     = 3,
  parameter bit MSB_FIRST      = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      pixel_en,
  input  logic [DATA_WIDTH_IN-1:0]  data_in,
  input  logic                      data_in_valid,
  input  logic                      generator_busy,
  output logic                      need_next,
  output logic [DATA_WIDTH_OUT-1:0] data_out,
  output logic                      data_out_valid,
  output logic                      underflow
`ifdef STALL_COUNT_EN
  ,
  output logic [15:0]               stall_count
`endif
);
  localparam int S  = DATA_WIDTH_IN / DATA_WIDTH_OUT;
  localparam int RW = $clog2(S);
  localparam int BW = $clog2(NUM_BANKS);
  localparam int CW = $clog2((IDLE_HOLD > VALID_HOLD ? IDLE_HOLD : VALID_HOLD) + 1);
  typedef enum logic [2:0] {IDLE, REQ, ACK, VALID, LOAD} state_t;
  state_t                    state;
  logic [DATA_WIDTH_IN-1:0]  bank [NUM_BANKS];
  logic [NUM_BANKS-1:0]      full;
  logic [BW-1:0]             wr_bank, rd_bank;
  logic [RW-1:0]             ra, sel;
  logic [CW-1:0]             cnt;
  logic [DATA_WIDTH_IN-1:0]  rd_word;
  logic [DATA_WIDTH_OUT-1:0] slice;
  assign sel     = MSB_FIRST ? RW'(S - 1) - ra : ra;
  assign rd_word = bank[rd_bank];
  assign slice   = rd_word[sel * DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
  // Bank storage needs no reset: the full flags alone decide what is readable.
  always_ff @(posedge clk)
    if (state == LOAD) bank[wr_bank] <= data_in;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      need_next      <= 1'b0;
      full           <= '0;
      wr_bank        <= '0;
      rd_bank        <= '0;
      ra             <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
`ifdef STALL_COUNT_EN
      stall_count    <= '0;
`endif
    end else if (frame_start) begin
      state          <= IDLE;
      cnt            <= '0;
      need_next      <= 1'b0;
      full           <= '0;
      wr_bank        <= '0;
      rd_bank        <= '0;
      ra             <= '0;
      data_out_valid <= 1'b0;
      underflow      <= 1'b0;
`ifdef STALL_COUNT_EN
      stall_count    <= '0;
`endif
    end else begin
      need_next      <= 1'b0;
      data_out_valid <= 1'b0;
      case (state)
        IDLE: if (!full[wr_bank]) begin
          state <= REQ;
          cnt   <= '0;
        end
        REQ: if (generator_busy) cnt <= '0;
        else if (cnt == CW'(IDLE_HOLD - 1)) begin
          need_next <= 1'b1;
          state     <= ACK;
          cnt       <= '0;
        end else cnt <= cnt + 1'b1;
        ACK: state <= VALID;
        VALID: if (!data_in_valid) cnt <= '0;
        else if (cnt == CW'(VALID_HOLD - 1)) begin
          state <= LOAD;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        LOAD: begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= wr_bank + 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // LOAD only ever targets an empty bank, so this drain never touches the bank being loaded.
      if (pixel_en) begin
        if (full[rd_bank]) begin
          data_out       <= slice;
          data_out_valid <= 1'b1;
          ra             <= (ra == RW'(S - 1)) ? '0 : ra + 1'b1;
          if (ra == RW'(S - 1)) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= rd_bank + 1'b1;
          end
        end else begin
          data_out  <= '0;
          underflow <= 1'b1;
`ifdef STALL_COUNT_EN
          stall_count <= stall_count + {15'd0, stall_count != 16'hFFFF};
`endif
        end
      end
    end
  end
endmodule
